// File: rtl/uart_pkg.sv
// Shared constants and send-sequencer state encoding for the UART transmit buffer.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_GAP   = 3'd4
  } tx_fsm_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic circular byte FIFO: registered storage, wrapping pointers, separate
// occupancy counter and a sticky overflow flag; flush outranks every other update.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = BYTE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic          flush,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Status flags decode the registered count only, so wr_en never reaches them.
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_push   = wr_en && !w_full && !flush;
  assign w_pop    = rd_en && !w_empty && !flush;

  assign rd_data  = r_mem[r_rd_ptr];
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of the UART transmitter: queues system writes and hands
// them to the transmitter one at a time via send_en/data_out/tx_done/tx_state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              send_en,
  output logic [BYTE_W-1:0] data_out,
  input  logic              tx_done,
  input  logic              tx_state
);

  tx_fsm_e           r_state;
  tx_fsm_e           w_next;
  logic              w_pop;
  logic              w_empty;
  logic [BYTE_W-1:0] w_rd_data;
  logic              r_send_en;
  logic [BYTE_W-1:0] r_data_out;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (BYTE_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (w_pop),
    .flush    (flush),
    .rd_data  (w_rd_data),
    .full     (full),
    .empty    (w_empty),
    .count    (count),
    .overflow (overflow)
  );

  assign empty    = w_empty;
  assign send_en  = r_send_en;
  assign data_out = r_data_out;

  // Send sequencer; flush never interrupts a byte that has already been popped.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !tx_state) begin
          w_pop  = 1'b1;
          w_next = S_LOAD;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LOAD:  w_next = S_START;
      S_START: w_next = S_BUSY;
      S_BUSY: begin
        if (tx_done) begin
          w_next = S_GAP;
        end else begin
          w_next = S_BUSY;
        end
      end
      S_GAP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_send_en  <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state   <= w_next;
      r_send_en <= (w_next == S_START);
      if (w_pop) begin
        r_data_out <= w_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized scoreboard bench for uart_tx_fifo with a queue-based timing model
// of the buffer and a simple UART responder.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        flush = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_state = 1'b0;
  logic        full, empty, overflow, send_en;
  logic [AW:0] count;
  logic [7:0]  data_out;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [7:0]  m_q[$];
  exp_t        exp_q[$];
  bit          m_ovf = 1'b0;
  bit          m_busy = 1'b0;
  int          m_pop_cyc = 0;
  int          m_ready = 0;
  bit          force_busy = 1'b0;
  bit          u_active = 1'b0;
  int          u_cnt = 0;
  logic [7:0]  last_sent = 8'h00;
  bit          have_last = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .send_en  (send_en),
    .data_out (data_out),
    .tx_done  (tx_done),
    .tx_state (tx_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Reference model: a byte leaves the queue when no transfer is pending, the
  // post-done gap has elapsed and the line is idle; its send_en is due 2 cycles later.
  initial begin
    forever begin
      int         pre;
      bit         pop;
      logic [7:0] b;
      @(posedge clk);
      if (!rst_n) begin
        m_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_busy = 1'b0;
        m_ready = 0;
      end else begin
        pre = m_q.size();
        pop = !m_busy && (cyc >= m_ready) && (pre > 0) && !tx_state;
        if (m_busy && tx_done && (cyc >= m_pop_cyc + 3)) begin
          m_busy = 1'b0;
          m_ready = cyc + 2;
        end
        if (pop) begin
          b = m_q.pop_front();
          exp_q.push_back('{b, cyc + 2});
          m_busy = 1'b1;
          m_pop_cyc = cyc;
        end
        if (flush) begin
          m_q.delete();
          m_ovf = 1'b0;
        end else if (wr_en) begin
          if (pre == DEPTH) m_ovf = 1'b1;
          else m_q.push_back(wr_data);
        end
      end
      cyc++;
    end
  end

  // UART responder: busy for a random length after each send_en, then a done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        u_active = 1'b0;
        u_cnt = 0;
        tx_done = 1'b0;
      end else if (tx_done) begin
        tx_done = 1'b0;
        u_active = 1'b0;
      end else if (u_active) begin
        if (u_cnt == 0) tx_done = 1'b1;
        else u_cnt--;
      end else if (send_en) begin
        u_active = 1'b1;
        u_cnt = $urandom_range(0, 5);
      end
      tx_state = u_active || force_busy;
    end
  end

  // Monitor: status against the model every cycle, send_en against the scoreboard.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #1;
      if (rst_n) begin
        check("count", int'(count), m_q.size());
        check("full", int'(full), int'(m_q.size() == DEPTH));
        check("empty", int'(empty), int'(m_q.size() == 0));
        check("overflow", int'(overflow), int'(m_ovf));
        if (send_en) begin
          if (exp_q.size() == 0) begin
            check("spurious_send_en", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("send_data", int'(data_out), int'(e.b));
            check("send_cycle", cyc, e.c);
          end
          last_sent = data_out;
          have_last = 1'b1;
        end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
          e = exp_q.pop_front();
          check("missed_send_en", 0, 1);
        end
        if (have_last && tx_state) begin
          check("data_out_stable", int'(data_out), int'(last_sent));
        end
      end else begin
        have_last = 1'b0;
      end
    end
  end

  task automatic drive(input bit we, input logic [7:0] d, input bit fl);
    @(negedge clk);
    wr_en = we;
    wr_data = d;
    flush = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((m_q.size() != 0 || m_busy || exp_q.size() != 0 || u_active) && k < budget) begin
      idle(1);
      k++;
    end
    if (k >= budget) check("drain_timeout", 1, 0);
    idle(4);
  endtask

  task automatic wait_uart(input int budget);
    int k;
    k = 0;
    while (!u_active && k < budget) begin
      idle(1);
      k++;
    end
    if (k >= budget) check("uart_start_timeout", 1, 0);
  endtask

  initial begin
    int i;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_send_en", int'(send_en), 0);
    check("rst_data_out", int'(data_out), 0);
    check("rst_empty", int'(empty), 1);

    // Single byte written in cycle 10: send_en due in cycle 13.
    while (cyc < 10) @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'hA5;
    idle(1);
    wait_drain(200);

    // Back-to-back burst.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    idle(1);
    wait_drain(300);

    // Fill with the line held busy; the 17th byte must be dropped.
    force_busy = 1'b1;
    idle(2);
    for (i = 0; i < DEPTH + 1; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    idle(2);
    check("fill_count", int'(count), DEPTH);
    check("fill_overflow", int'(overflow), 1);
    force_busy = 1'b0;
    wait_drain(1000);
    drive(1'b0, 8'h00, 1'b1);
    idle(1);

    // Pointer wrap: 20 ascending bytes, writing only while the buffer has room.
    i = 0;
    while (i < 20) begin
      if (m_q.size() < DEPTH) begin
        drive(1'b1, 8'(i), 1'b0);
        i++;
      end else begin
        idle(1);
      end
    end
    idle(1);
    wait_drain(1000);

    // Flush while byte 0 is on the line.
    for (i = 0; i < 4; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
    idle(1);
    wait_uart(50);
    drive(1'b0, 8'h00, 1'b1);
    idle(1);
    wait_drain(200);
    idle(20);

    // Reset during a transfer.
    drive(1'b1, 8'h5A, 1'b0);
    idle(1);
    wait_uart(50);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_send_en", int'(send_en), 0);
    check("async_rst_data_out", int'(data_out), 0);
    check("async_rst_count", int'(count), 0);
    check("async_rst_empty", int'(empty), 1);
    check("async_rst_full", int'(full), 0);
    check("async_rst_overflow", int'(overflow), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(15);

    // Random traffic with occasional flushes.
    for (i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)), ($urandom_range(0, 79) == 0));
    end
    idle(1);
    wait_drain(2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and send sequencer directly upstream of the UART top level.
- Accepts bytes from the system side with a write strobe and stores them in a circular FIFO.
- Feeds the UART transmitter one byte at a time through the send_en/data_out/tx_done/tx_state handshake, so software-side writers never have to watch the serial line timing.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe; one byte per cycle.
- wr_data  input  8  byte to enqueue.
- flush  input  1  synchronous clear of stored contents.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  AW+1  number of stored entries (0..DEPTH).
- overflow  output  1  sticky flag: a write was dropped; cleared by flush or reset.
- send_en  output  1  one-cycle pulse to UART transmitter start.
- data_out  output  8  byte presented to UART transmitter.
- tx_done  input  1  one-cycle pulse from UART at end of stop bit.
- tx_state  input  1  high while UART transmitter is busy.

Behaviour:
- Reset (async, rst_n low): pointers 0, count 0, empty 1, full 0, overflow 0, send_en 0, data_out 8'h00, FSM in IDLE. Asserting reset mid-frame abandons the in-flight byte; the UART is reset by the same rst_n.
- Storage: registered array, write pointer and read pointer AW bits wide, wrap modulo DEPTH. count is a separate AW+1 register; full = (count==DEPTH), empty = (count==0), both registered-derived with no combinational path from wr_en.
- Write: wr_en && !full stores wr_data at wr_ptr and increments it. wr_en && full drops the byte, leaves the FIFO unchanged and sets overflow. Full is judged on the pre-cycle value, so a write while full is dropped even if a pop occurs the same cycle.
- Pop: performed only by the FSM (below). A simultaneous write and pop leaves count unchanged; both pointers advance.
- FSM states: IDLE, LOAD, START, BUSY, GAP.
  - IDLE: if !empty && !tx_state, pop the head into the data_out register and go to LOAD.
  - LOAD: data_out is stable; go to START.
  - START: send_en=1 for exactly this cycle; go to BUSY.
  - BUSY: wait for tx_done=1, then go to GAP. send_en stays 0.
  - GAP: one idle cycle; go to IDLE.
- data_out holds its value from LOAD until the next LOAD; it never changes while tx_state is high.
- Latency: a byte written into an empty FIFO at cycle N is counted at N+1; the pop occurs at N+1 (IDLE sees !empty), LOAD at N+2, and the send_en pulse at N+3.
- Back-to-back frames: the next send_en comes no earlier than 4 cycles after tx_done (GAP, IDLE, LOAD, START).
- tx_done outside BUSY is ignored.
- flush: clears pointers, count and overflow in one cycle and has priority over wr_en. If the FSM is in LOAD/START/BUSY/GAP, the popped byte still completes normally; flush does not abort the transfer.
- A tx_state already high in IDLE (for example, the UART driven externally) blocks popping until it falls.

Decomposition:
- Shared package uart_pkg: byte width constant (8) and FSM state encoding (IDLE=0, LOAD=1, START=2, BUSY=3, GAP=4, 3-bit).
- Natural sub-module: sync_fifo (generic storage, pointers, count, full/empty, overflow), instantiated by uart_tx_fifo, which adds the send FSM.

Test Plan:
- Single byte: reset, write 8'hA5 at cycle 10 → count=1 at 11, send_en pulse at cycle 13 with data_out=8'hA5; model UART raises tx_state and returns tx_done → empty=1, FSM back to IDLE.
- Burst of 3 (8'h11, 8'h22, 8'h33) on consecutive cycles → three send_en pulses in order 11, 22, 33, each at least 4 cycles after the previous tx_done, with data_out stable throughout each tx_state high.
- Fill and overflow: hold tx_state high and write 17 bytes with DEPTH=16 → full=1, count=16, overflow=1, 17th byte absent from the output sequence.
- Pointer wrap: write/send 20 bytes 0x00..0x13 continuously → output order exactly 0x00..0x13, count never exceeds 16.
- Flush mid-frame: 4 bytes queued, flush during BUSY of byte 0 → tx_done still accepted, count=0, overflow=0, no further send_en.
- Reset mid-frame: rst_n low during BUSY → all outputs at reset values immediately (async), no send_en after release until a new write.
